// File: rtl/tri_bus_pkg.sv
// Shared definitions for the tri-state bus arbiter: FSM state encoding and
// default sizing constants used by the top level and the round-robin picker.
package tri_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_N_AGENTS  = 4;
    localparam int DEF_MAX_BURST = 4;

    // Beat counter width; large enough for the largest allowed burst of 15.
    localparam int BEAT_W = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: starting one past the previous owner,
// returns the first requesting agent as a one-hot vector and as an index.
import tri_bus_pkg::*;

module rr_arbiter #(
    parameter int N_AGENTS = DEF_N_AGENTS,
    localparam int IW = $clog2(N_AGENTS)
) (
    input  logic [N_AGENTS-1:0] req,
    input  logic [IW-1:0]       last_owner,
    output logic [N_AGENTS-1:0] winner,
    output logic [IW-1:0]       winner_idx
);

    logic found;
    int   idx;

    // Scan agents in priority order last_owner+1, last_owner+2, ... wrapping.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        idx        = 0;
        for (int i = 1; i <= N_AGENTS; i++) begin
            idx = (int'(last_owner) + i) % N_AGENTS;
            if (!found && req[idx]) begin
                found       = 1'b1;
                winner[idx] = 1'b1;
                winner_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Tri-state shared bus arbiter. Agents request the bus, a round-robin winner
// drives bus_data for up to MAX_BURST beats, then one turnaround cycle keeps
// the bus released before the next arbitration. Every driven beat is captured
// into data_from_bus with a one-cycle rx_valid pulse.
// Optional feature: define BUS_PARITY_EN to add an even-parity bit (bus_par)
// alongside the bus and a par_err pulse on captured parity mismatch.
import tri_bus_pkg::*;

module tri_bus_arbiter #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int N_AGENTS  = DEF_N_AGENTS,
    parameter int MAX_BURST = DEF_MAX_BURST,
    localparam int IW = $clog2(N_AGENTS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_AGENTS-1:0]       req,
    input  logic [N_AGENTS*WIDTH-1:0] data_to_bus,
    output logic [N_AGENTS-1:0]       grant,
    inout  wire  [WIDTH-1:0]          bus_data,
`ifdef BUS_PARITY_EN
    inout  wire                       bus_par,
    output logic                      par_err,
`endif
    output logic [WIDTH-1:0]          data_from_bus,
    output logic                      rx_valid,
    output logic [IW-1:0]             rx_src,
    output logic                      busy
);

    state_t              state, state_n;
    logic [N_AGENTS-1:0] grant_n;
    logic [IW-1:0]       owner, owner_n;
    logic [IW-1:0]       last_owner, last_owner_n;
    logic [BEAT_W-1:0]   beat_cnt, beat_cnt_n;
    logic [BEAT_W:0]     beat_inc;
    logic                burst_done;
    logic                drive_en;
    logic [N_AGENTS-1:0] win;
    logic [IW-1:0]       win_idx;
    logic [WIDTH-1:0]    owner_data;

    rr_arbiter #(.N_AGENTS(N_AGENTS)) u_rr (
        .req        (req),
        .last_owner (last_owner),
        .winner     (win),
        .winner_idx (win_idx)
    );

    // The bus is only driven while the owner is still requesting, so the
    // cycle in which the owner drops its request is released immediately.
    assign drive_en   = (state == ST_DRIVE) && req[owner];
    assign owner_data = data_to_bus[int'(owner)*WIDTH +: WIDTH];
    assign bus_data   = drive_en ? owner_data : {WIDTH{1'bz}};
`ifdef BUS_PARITY_EN
    assign bus_par    = drive_en ? ^owner_data : 1'bz;
`endif

    assign beat_inc   = {1'b0, beat_cnt} + {{BEAT_W{1'b0}}, 1'b1};
    assign burst_done = (beat_inc == (BEAT_W+1)'(MAX_BURST));
    assign busy       = (state != ST_IDLE);

    // State register and registered grant/owner bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= '0;
            owner      <= '0;
            last_owner <= IW'(N_AGENTS - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
            beat_cnt   <= beat_cnt_n;
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats in DRIVE, one TURN cycle.
    always_comb begin
        state_n      = state;
        grant_n      = grant;
        owner_n      = owner;
        last_owner_n = last_owner;
        beat_cnt_n   = beat_cnt;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_n      = ST_DRIVE;
                    grant_n      = win;
                    owner_n      = win_idx;
                    last_owner_n = win_idx;
                    beat_cnt_n   = '0;
                end
            end
            ST_DRIVE: begin
                if (!req[owner] || burst_done) begin
                    state_n    = ST_TURN;
                    grant_n    = '0;
                    beat_cnt_n = '0;
                end else begin
                    beat_cnt_n = beat_inc[BEAT_W-1:0];
                end
            end
            ST_TURN: begin
                state_n = ST_IDLE;
                grant_n = '0;
            end
            default: begin
                state_n = ST_IDLE;
                grant_n = '0;
            end
        endcase
    end

    // Capture each driven beat from the shared bus and flag it for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_from_bus <= '0;
            rx_valid      <= 1'b0;
            rx_src        <= '0;
`ifdef BUS_PARITY_EN
            par_err       <= 1'b0;
`endif
        end else begin
            rx_valid <= drive_en;
`ifdef BUS_PARITY_EN
            par_err  <= drive_en && ((^bus_data) != bus_par);
`endif
            if (drive_en) begin
                data_from_bus <= bus_data;
                rx_src        <= owner;
            end
        end
    end

endmodule

// File: doc/tri_bus_arbiter.md
TRI_BUS_ARBITER -- requirements
Module: tri_bus_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, bus data width in bits.
REQ-002 Parameter N_AGENTS, default 4, number of requesting agents (2..8).
REQ-003 Parameter MAX_BURST, default 4, max consecutive beats per grant (1..15).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req  input  N_AGENTS  per-agent bus request, level.
REQ-007 data_to_bus  input  N_AGENTS*WIDTH  agent i data in slice [i*WIDTH +: WIDTH].
REQ-008 grant  output  N_AGENTS  one-hot owner; all-zero when no owner.
REQ-009 bus_data  inout  WIDTH  shared tristate bus.
REQ-010 data_from_bus  output  WIDTH  last beat captured from bus_data.
REQ-011 rx_valid  output  1  one-cycle pulse: data_from_bus updated.
REQ-012 rx_src  output  $clog2(N_AGENTS)  index of agent that sent captured beat.
REQ-013 busy  output  1  high in DRIVE or TURN.

Function
REQ-014 FSM states IDLE, DRIVE, TURN; encoding in shared package.
REQ-015 IDLE: if any req, select winner round-robin starting at (last_owner+1) mod N_AGENTS, set grant, go DRIVE next edge; else stay.
REQ-016 Grant latency: req high at edge t -> grant high from edge t+1.
REQ-017 DRIVE: bus_data = granted agent's slice; every other time bus_data = 'z.
REQ-018 DRIVE: beat counter increments each cycle; stay while owner req high and count < MAX_BURST.
REQ-019 DRIVE exit (owner req low or count == MAX_BURST): grant cleared, go TURN.
REQ-020 TURN: exactly one cycle, bus high-Z, grant zero; then IDLE (re-arbitrate next cycle).
REQ-021 Each DRIVE cycle: data_from_bus <= bus_data, rx_src <= owner, rx_valid high the following cycle.
REQ-022 Owner dropping req mid-burst: the drop cycle is not driven (grant cleared same edge FSM leaves DRIVE); no partial beat captured.
REQ-023 Non-owner req changes during DRIVE ignored until next arbitration.
REQ-024 Single requester: repeats DRIVE/TURN/IDLE; max throughput MAX_BURST beats per MAX_BURST+2 cycles.
REQ-025 grant never has more than one bit set; bus never driven in TURN or IDLE.

Reset
REQ-026 rst_n low at edge: state IDLE, grant 0, bus high-Z, data_from_bus 0, rx_valid 0, rx_src 0, busy 0, beat counter 0, last_owner N_AGENTS-1 (agent 0 wins first).
REQ-027 Reset mid-burst: bus released at that edge, no rx_valid follows.

Configuration
REQ-028 Macro BUS_PARITY_EN: adds inout bus_par (1) driven with even parity of driven data in DRIVE, and output par_err pulsed with rx_valid when captured parity mismatches.
REQ-029 Without BUS_PARITY_EN: no bus_par/par_err ports; all other behaviour identical.

Structure
REQ-030 Package tri_bus_pkg: state enum, default WIDTH/N_AGENTS/MAX_BURST constants.
REQ-031 Sub-module rr_arbiter (req, last_owner -> one-hot winner, combinational) instantiated once.

Verification
REQ-032 Agent1 req=1, data 8'hA5, others idle -> grant=4'b0010 next cycle; data_from_bus=8'hA5, rx_src=1, rx_valid pulse one cycle later.
REQ-033 req=4'b1111 held, MAX_BURST=4 -> grants 0,1,2,3,0 in order, each 4 beats, one TURN cycle between, never two grant bits.
REQ-034 Agent2 drops req after 2 beats -> exactly 2 rx_valid pulses, TURN, bus 'z within one cycle.
REQ-035 rst_n low during beat 3 of burst -> grant 0, bus 'z next edge, no further rx_valid; after release agent 0 wins first.
REQ-036 BUS_PARITY_EN, external driver forces bus_par wrong during beat 8'h3C -> par_err pulses with rx_valid; without macro build compiles and passes REQ-032.
REQ-037 No req for 20 cycles -> busy 0, bus_data 'z, rx_valid never asserted.
